qerv_rf_ram_arb: RTL
====================

// Module: qerv_rf_ram_arb
// PURPOSE
//  Sequencer/arbiter between qerv_rf_ram_if (core side) and serv_rf_ram (RAM side).
//  After reset it zero-fills the whole RF RAM while holding the core in reset, then
//  hands the RAM to the core. A debug/preload master can halt the core and then
//  read or write raw RF RAM words, e.g. to preload GPRs/CSRs or inspect them.
//  o_core_rst drives the reset of both qerv_top and qerv_rf_ram_if.
// PARAMETERS
//  WIDTH     8   RF RAM word width (matches RF_WIDTH)
//  CSR_REGS  4   CSR registers stored in RF RAM (0 or 4)
//  DEPTH     (32+CSR_REGS)*32/WIDTH   RAM words (144 with defaults)
//  L2D       $clog2(DEPTH)            RAM address width (8 with defaults)
//  CLEAR     1   1: zero-fill RAM after reset; 0: skip the fill
// PORTS
//  clk           in   1      clock
//  i_rst         in   1      asynchronous reset, active high
//  o_core_rst    out  1      reset to core and rf_ram_if; high unless state==RUN
//  i_core_waddr  in   L2D    core write address
//  i_core_wdata  in   WIDTH  core write data
//  i_core_wen    in   1      core write enable
//  i_core_raddr  in   L2D    core read address
//  i_core_ren    in   1      core read enable
//  o_core_rdata  out  WIDTH  read data to core; equals i_ram_rdata
//  o_ram_waddr   out  L2D    RAM write address
//  o_ram_wdata   out  WIDTH  RAM write data
//  o_ram_wen     out  1      RAM write enable
//  o_ram_raddr   out  L2D    RAM read address
//  o_ram_ren     out  1      RAM read enable
//  i_ram_rdata   in   WIDTH  RAM read data; valid 1 cycle after ren
//  i_dbg_halt    in   1      level: request core halt
//  o_dbg_halted  out  1      core halted; debug master owns the RAM
//  i_dbg_cyc     in   1      debug access request; held until o_dbg_ack
//  i_dbg_we      in   1      1 = write, 0 = read
//  i_dbg_adr     in   L2D    debug word address
//  i_dbg_dat     in   WIDTH  debug write data
//  o_dbg_rdt     out  WIDTH  debug read data; valid while o_dbg_ack is high
//  o_dbg_ack     out  1      one-cycle access acknowledge
// BEHAVIOUR
//  States: INIT, CLEAR, RUN, HALTED. Async reset: state=INIT, cnt=0, ack=0.
//  Outputs during reset: o_core_rst=1, o_dbg_halted=0, o_dbg_ack=0, RAM wen/ren=0.
//  INIT: 1 cycle. Next state is CLEAR if CLEAR=1, else RUN.
//  CLEAR: o_ram_wen=1, waddr=cnt, wdata=0, ren=0; cnt increments each cycle.
//   At cnt==DEPTH-1: go to HALTED if i_dbg_halt, else RUN; cnt returns to 0.
//   i_dbg_halt does not abort CLEAR.
//  RUN: RAM ports = core ports, passed through combinationally; o_core_rst=0.
//   i_dbg_halt=1 -> HALTED at the next edge; the core instruction in progress is abandoned.
//   After release the core restarts at RESET_PC.
//  HALTED: o_core_rst=1, o_dbg_halted=1; core RAM inputs ignored; RAM ports = debug.
//   Accept when i_dbg_cyc & !ack in cycle N:
//    write: o_ram_wen=1 in cycle N;
//    read: o_ram_ren=1, raddr=i_dbg_adr in cycle N.
//   o_dbg_ack=1 in cycle N+1 only; o_dbg_rdt=i_ram_rdata in N+1.
//   No new accept while ack is high, so back-to-back accesses take 2 cycles each.
//   Only one access is ever outstanding.
//   i_dbg_halt=0 with no ack pending -> RUN at the next edge.
//   If halt drops in cycle N of an access, the ack in N+1 still occurs; RUN follows at N+2.
//  i_dbg_cyc outside HALTED: ignored, never acked, RAM untouched.
//  Reset asserted mid-CLEAR or mid-access: immediate INIT, ack drops, no further RAM writes.
//   The fill restarts from address 0.
//  o_core_rdata = i_ram_rdata always. The core never reads in non-RUN states.
// TESTING
//  Reset release, CLEAR=1 -> wen=1 for waddr 0..143 with wdata 0.
//   o_core_rst falls after exactly 145 rising edges.
//  CLEAR=0 -> o_core_rst falls after 1 edge; no RAM write issued.
//  RUN, core wen with waddr=0x25 wdata=0xA5 -> same values appear on RAM port in the same cycle.
//  Halt; debug write adr 0x10 dat 0x3C, then read 0x10 -> ack 1 cycle after each accept.
//   Read returns o_dbg_rdt=0x3C. Release halt -> o_core_rst low 1 edge later.
//  i_dbg_cyc in RUN for 10 cycles -> no ack, no RAM enable.
//   Halt raised at CLEAR address 50 -> fill completes, then HALTED.
//  i_rst pulsed while a debug read is pending -> ack never fires; the fill restarts at address 0.

Source files
------------

// File: rtl/qerv_rf_ram_arb.sv
// ============================================================================
// Module  : qerv_rf_ram_arb
// Brief   : RF RAM sequencer/arbiter: post-reset zero-fill, core pass-through,
//           and debug halt with raw RF RAM word access.
// Revision: 1.0
// ============================================================================
`default_nettype none

module qerv_rf_ram_arb #(
    parameter int WIDTH    = 8,
    parameter int CSR_REGS = 4,
    parameter int DEPTH    = (32 + CSR_REGS) * 32 / WIDTH,
    parameter int L2D      = $clog2(DEPTH),
    parameter int CLEAR    = 1
) (
    input  logic             clk,
    input  logic             i_rst,
    output logic             o_core_rst,
    input  logic [L2D-1:0]   i_core_waddr,
    input  logic [WIDTH-1:0] i_core_wdata,
    input  logic             i_core_wen,
    input  logic [L2D-1:0]   i_core_raddr,
    input  logic             i_core_ren,
    output logic [WIDTH-1:0] o_core_rdata,
    output logic [L2D-1:0]   o_ram_waddr,
    output logic [WIDTH-1:0] o_ram_wdata,
    output logic             o_ram_wen,
    output logic [L2D-1:0]   o_ram_raddr,
    output logic             o_ram_ren,
    input  logic [WIDTH-1:0] i_ram_rdata,
    input  logic             i_dbg_halt,
    output logic             o_dbg_halted,
    input  logic             i_dbg_cyc,
    input  logic             i_dbg_we,
    input  logic [L2D-1:0]   i_dbg_adr,
    input  logic [WIDTH-1:0] i_dbg_dat,
    output logic [WIDTH-1:0] o_dbg_rdt,
    output logic             o_dbg_ack
);

    localparam logic [1:0] c_INIT   = 2'd0;
    localparam logic [1:0] c_CLEAR  = 2'd1;
    localparam logic [1:0] c_RUN    = 2'd2;
    localparam logic [1:0] c_HALTED = 2'd3;

    localparam logic [L2D-1:0] c_LAST = L2D'(DEPTH - 1);
    localparam logic [L2D-1:0] c_ONE  = L2D'(1);

    logic [1:0]     state_q, state_d;
    logic [L2D-1:0] cnt_q, cnt_d;
    logic           ack_q, ack_d;
    logic           w_accept;

    // A new debug access is only taken while halted and no ack is in flight.
    assign w_accept = (state_q == c_HALTED) && i_dbg_cyc && !ack_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        case (state_q)
            c_INIT: begin
                cnt_d   = '0;
                state_d = (CLEAR != 0) ? c_CLEAR : c_RUN;
            end
            c_CLEAR: begin
                if (cnt_q == c_LAST) begin
                    cnt_d   = '0;
                    state_d = i_dbg_halt ? c_HALTED : c_RUN;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            c_RUN: begin
                if (i_dbg_halt) state_d = c_HALTED;
            end
            c_HALTED: begin
                ack_d = w_accept;
                // An access accepted this cycle keeps us halted until its ack.
                if (!i_dbg_halt && !w_accept) state_d = c_RUN;
            end
            default: state_d = c_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= c_INIT;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        o_ram_waddr = '0;
        o_ram_wdata = '0;
        o_ram_wen   = 1'b0;
        o_ram_raddr = '0;
        o_ram_ren   = 1'b0;
        case (state_q)
            c_CLEAR: begin
                o_ram_waddr = cnt_q;
                o_ram_wen   = 1'b1;
            end
            c_RUN: begin
                o_ram_waddr = i_core_waddr;
                o_ram_wdata = i_core_wdata;
                o_ram_wen   = i_core_wen;
                o_ram_raddr = i_core_raddr;
                o_ram_ren   = i_core_ren;
            end
            c_HALTED: begin
                o_ram_waddr = i_dbg_adr;
                o_ram_wdata = i_dbg_dat;
                o_ram_wen   = w_accept && i_dbg_we;
                o_ram_raddr = i_dbg_adr;
                o_ram_ren   = w_accept && !i_dbg_we;
            end
            default: ;
        endcase
    end

    assign o_core_rst   = (state_q != c_RUN);
    assign o_dbg_halted = (state_q == c_HALTED);
    assign o_dbg_ack    = ack_q;
    assign o_dbg_rdt    = i_ram_rdata;
    assign o_core_rdata = i_ram_rdata;

endmodule

`default_nettype wire
